// File: rtl/regdump_pkg.sv
// Shared constants for the register-file dump reader: default widths and FSM state encoding.
package regdump_pkg;

  localparam int unsigned NumRegsDef  = 32;
  localparam int unsigned FirstRegDef = 0;
  localparam int unsigned AddrWDef    = 5;
  localparam int unsigned DataWDef    = 32;
  localparam int unsigned IdxWDef     = 6;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StSend  = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one read port and streams each register as a valid/ready beat.
// Optional trailing XOR checksum beat is enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NumRegsDef,
  parameter int unsigned FIRST_REG = FirstRegDef,
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned IDX_W     = IdxWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_index_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_REGS - 1);

  if (FIRST_REG > NUM_REGS - 1) begin : g_bad_first_reg
    $error("regfile_dump_reader: FIRST_REG (%0d) exceeds NUM_REGS-1 (%0d)",
           FIRST_REG, NUM_REGS - 1);
  end

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic              out_last_q, out_last_d;

`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [IDX_W-1:0] CsumIdx = IDX_W'(NUM_REGS);
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      StIdle: begin
        // abort in the same cycle suppresses a start
        if (start_i && !abort_i) begin
          idx_d   = FirstIdx;
          state_d = StFetch;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StFetch: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          out_data_d  = rd_data_i;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          out_last_d  = 1'b0;
`else
          out_last_d  = (idx_q == LastIdx);
`endif
          state_d     = StSend;
        end
      end
      StSend: begin
        if (abort_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (idx_q < LastIdx) begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      StCsum: begin
        // First cycle loads the checksum beat, then it waits for its handshake
        if (abort_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (!out_valid_q) begin
          out_data_d  = csum_q;
          out_index_d = CsumIdx;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StDone;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= FirstIdx;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Address stays on idx outside IDLE so a skipped x0 is never presented while busy
  assign rd_addr_o   = (state_q == StIdle) ? '0 : idx_q[ADDR_W-1:0];
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);

endmodule
